// File: rtl/ixu_alu_arbiter_if.sv
// Lane-request, ALU-issue and result bundle shared by ixu_alu_arbiter and its neighbours.
// slave = arbiter side, master = lanes / ALU / writeback side.
interface ixu_alu_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 5
);
  localparam int LANE_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*4-1:0]     req_op;
  logic [N_REQ*32-1:0]    req_rs1;
  logic [N_REQ*32-1:0]    req_rs2;
  logic [N_REQ*20-1:0]    req_imm;
  logic [N_REQ-1:0]       req_is_imm;
  logic [N_REQ-1:0]       req_is_nop;
  logic [N_REQ*32-1:0]    req_pc;
  logic [N_REQ*TAG_W-1:0] req_tag;

  logic [31:0] alu_rs1_data;
  logic [31:0] alu_rs2_data;
  logic [19:0] alu_imm;
  logic        alu_is_imm_type;
  logic        alu_is_nop;
  logic [3:0]  alu_op;
  logic [31:0] alu_ex_pc_in;
  logic        alu_is_rs1_fwd;
  logic        alu_is_rs2_fwd;
  logic [31:0] alu_out;

  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [LANE_W-1:0] res_lane;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_imm, req_is_imm, req_is_nop, req_pc, req_tag,
    output req_ready,
    output alu_rs1_data, alu_rs2_data, alu_imm, alu_is_imm_type, alu_is_nop, alu_op,
    output alu_ex_pc_in, alu_is_rs1_fwd, alu_is_rs2_fwd,
    input  alu_out,
    output res_valid, res_data, res_lane, res_tag, res_err,
    input  res_ready
  );

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_imm, req_is_imm, req_is_nop, req_pc, req_tag,
    input  req_ready,
    input  alu_rs1_data, alu_rs2_data, alu_imm, alu_is_imm_type, alu_is_nop, alu_op,
    input  alu_ex_pc_in, alu_is_rs1_fwd, alu_is_rs2_fwd,
    output alu_out,
    input  res_valid, res_data, res_lane, res_tag, res_err,
    output res_ready
  );
endinterface

// File: rtl/ixu_alu_arbiter.sv
// Shares one ixu_execute ALU between N_REQ lanes through a registered issue stage (S1) and
// result stage (S2). Define IXU_ARB_RR_EN for round-robin; otherwise lowest lane wins.
module ixu_alu_arbiter #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  ixu_alu_arbiter_if.slave bus
);
  localparam int LANE_W = $clog2(N_REQ);

  typedef struct packed {
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    logic [19:0]       imm;
    logic              is_imm;
    logic              is_nop;
    logic [3:0]        op;
    logic [31:0]       pc;
    logic [LANE_W-1:0] lane;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } s1_t;

  typedef struct packed {
    logic [31:0]       data;
    logic [LANE_W-1:0] lane;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } s2_t;

  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic              adv1_s, adv2_s;
  logic              any_req_s;
  logic [LANE_W-1:0] sel_s;
  logic [N_REQ-1:0]  grant_s;

`ifdef IXU_ARB_RR_EN
  logic [LANE_W-1:0] ptr_q, ptr_d;
  int                idx_v;
`endif

  assign adv2_s = !s2_valid_q || bus.res_ready;
  assign adv1_s = !s1_valid_q || adv2_s;

  // Winner search; the loop runs from the far end so the first candidate in search order wins
  always_comb begin
    sel_s     = '0;
    any_req_s = 1'b0;
`ifdef IXU_ARB_RR_EN
    idx_v     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_v     = (int'(ptr_q) + k) % N_REQ;
      any_req_s = any_req_s | bus.req_valid[idx_v];
      sel_s     = bus.req_valid[idx_v] ? LANE_W'(idx_v) : sel_s;
    end
`else
    for (int k = N_REQ - 1; k >= 0; k--) begin
      any_req_s = any_req_s | bus.req_valid[k];
      sel_s     = bus.req_valid[k] ? LANE_W'(k) : sel_s;
    end
`endif
  end

  // One-hot grant, withheld during reset, flush and a full stall
  always_comb begin
    grant_s        = '0;
    grant_s[sel_s] = any_req_s && adv1_s && !flush && rst_n;
  end

`ifdef IXU_ARB_RR_EN
  // Pointer steps past the lane that was actually accepted
  always_comb begin
    ptr_d = (|grant_s) ? LANE_W'((int'(sel_s) + 1) % N_REQ) : ptr_q;
  end
`endif

  // Pipeline next state; flush wins over both advance conditions
  always_comb begin
    s1_d       = s1_q;
    s2_d       = s2_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (adv2_s) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_d.data = bus.alu_out;
          s2_d.lane = s1_q.lane;
          s2_d.tag  = s1_q.tag;
          s2_d.err  = s1_q.err;
        end else begin
          s2_d = s2_q;
        end
      end else begin
        s2_valid_d = s2_valid_q;
      end
      if (adv1_s) begin
        s1_valid_d = any_req_s;
        if (any_req_s) begin
          s1_d.rs1    = bus.req_rs1[sel_s * 32 +: 32];
          s1_d.rs2    = bus.req_rs2[sel_s * 32 +: 32];
          s1_d.imm    = bus.req_imm[sel_s * 20 +: 20];
          s1_d.is_imm = bus.req_is_imm[sel_s];
          s1_d.is_nop = bus.req_is_nop[sel_s];
          s1_d.op     = bus.req_op[sel_s * 4 +: 4];
          s1_d.pc     = bus.req_pc[sel_s * 32 +: 32];
          s1_d.lane   = sel_s;
          s1_d.tag    = bus.req_tag[sel_s * TAG_W +: TAG_W];
          s1_d.err    = (bus.req_op[sel_s * 4 +: 4] >= 4'hC) && !bus.req_is_nop[sel_s];
        end else begin
          s1_d = s1_q;
        end
      end else begin
        s1_valid_d = s1_valid_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
`ifdef IXU_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
`ifdef IXU_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.req_ready       = grant_s;
  assign bus.alu_rs1_data    = s1_q.rs1;
  assign bus.alu_rs2_data    = s1_q.rs2;
  assign bus.alu_imm         = s1_q.imm;
  assign bus.alu_is_imm_type = s1_q.is_imm;
  assign bus.alu_is_nop      = s1_q.is_nop;
  assign bus.alu_op          = s1_q.op;
  assign bus.alu_ex_pc_in    = s1_q.pc;
  // Operands arrive already resolved, so the ALU forwarding muxes are never used
  assign bus.alu_is_rs1_fwd  = 1'b0;
  assign bus.alu_is_rs2_fwd  = 1'b0;
  assign bus.res_valid       = s2_valid_q;
  assign bus.res_data        = s2_q.data;
  assign bus.res_lane        = s2_q.lane;
  assign bus.res_tag         = s2_q.tag;
  assign bus.res_err         = s2_q.err;
endmodule

// File: tb/tb_ixu_alu_arbiter.sv
// Directed bench for ixu_alu_arbiter with a small behavioural stand-in for ixu_execute.
module tb_ixu_alu_arbiter;
  logic clk;
  logic rst_n;
  logic flush;
  int   n_tests;
  int   n_fail;
  logic [31:0] opb;
  logic [1:0]  exp_rdy  [4];
  logic [0:0]  exp_lane [4];
  logic [31:0] exp_data [4];

  ixu_alu_arbiter_if #(.N_REQ(2), .TAG_W(5)) bus();

  ixu_alu_arbiter #(.N_REQ(2), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ALU stand-in: only ops 0x0..0xB are defined, NOP forces zero
  always_comb begin
    opb = bus.alu_is_imm_type ? {{12{bus.alu_imm[19]}}, bus.alu_imm} : bus.alu_rs2_data;
    case (bus.alu_op)
      4'h0:    bus.alu_out = bus.alu_rs1_data + opb;
      4'h1:    bus.alu_out = bus.alu_rs1_data - opb;
      4'h2:    bus.alu_out = bus.alu_rs1_data & opb;
      4'h3:    bus.alu_out = bus.alu_rs1_data | opb;
      4'h4:    bus.alu_out = bus.alu_rs1_data ^ opb;
      4'h5:    bus.alu_out = bus.alu_rs1_data << opb[4:0];
      4'h6:    bus.alu_out = bus.alu_rs1_data >> opb[4:0];
      4'h7:    bus.alu_out = $signed(bus.alu_rs1_data) >>> opb[4:0];
      4'h8:    bus.alu_out = {31'd0, $signed(bus.alu_rs1_data) < $signed(opb)};
      4'h9:    bus.alu_out = {31'd0, bus.alu_rs1_data < opb};
      4'hA:    bus.alu_out = {bus.alu_imm, 12'd0};
      4'hB:    bus.alu_out = bus.alu_ex_pc_in + {bus.alu_imm, 12'd0};
      default: bus.alu_out = 32'hDEADBEEF;
    endcase
    if (bus.alu_is_nop) begin
      bus.alu_out = 32'd0;
    end else begin
      bus.alu_out = bus.alu_out;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [3:0] op,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic nop, input logic [4:0] tag);
    bus.req_valid[l]        = v;
    bus.req_op[l*4 +: 4]    = op;
    bus.req_rs1[l*32 +: 32] = rs1;
    bus.req_rs2[l*32 +: 32] = rs2;
    bus.req_imm[l*20 +: 20] = 20'd0;
    bus.req_is_imm[l]       = 1'b0;
    bus.req_is_nop[l]       = nop;
    bus.req_pc[l*32 +: 32]  = 32'd0;
    bus.req_tag[l*5 +: 5]   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    bus.res_ready = 1'b1;
    set_lane(0, 1'b1, 4'h0, 32'd3, 32'd4, 1'b0, 5'd1);
    set_lane(1, 1'b1, 4'h0, 32'd3, 32'd4, 1'b0, 5'd2);
`ifdef IXU_ARB_RR_EN
    exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_lane = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{32'd2, 32'd30, 32'd2, 32'd30};
`else
    exp_rdy  = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_lane = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_data = '{32'd2, 32'd2, 32'd2, 32'd2};
`endif

    // Reset state with both lanes requesting
    #2;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data",  bus.res_data, 32'd0);
    chk("rst_alu_op",    bus.alu_op, 4'd0);
    chk("rst_alu_rs1",   bus.alu_rs1_data, 32'd0);
    chk("rst_res_tag",   bus.res_tag, 5'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single ADD on lane 0
    set_lane(0, 1'b1, 4'h0, 32'd5, 32'd7, 1'b0, 5'd3);
    #1;
    chk("add_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    chk("add_alu_op",    bus.alu_op, 4'h0);
    chk("add_alu_rs1",   bus.alu_rs1_data, 32'd5);
    chk("add_alu_rs2",   bus.alu_rs2_data, 32'd7);
    chk("add_res_early", bus.res_valid, 1'b0);
    tick();
    chk("add_res_valid", bus.res_valid, 1'b1);
    chk("add_res_data",  bus.res_data, 32'd12);
    chk("add_res_lane",  bus.res_lane, 1'b0);
    chk("add_res_tag",   bus.res_tag, 5'd3);
    chk("add_res_err",   bus.res_err, 1'b0);
    tick();
    chk("add_drained", bus.res_valid, 1'b0);

    // Invalid op on lane 0
    set_lane(0, 1'b1, 4'hE, 32'd1, 32'd2, 1'b0, 5'd7);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("inv_res_err",  bus.res_err, 1'b1);
    chk("inv_res_data", bus.res_data, 32'hDEADBEEF);
    chk("inv_res_tag",  bus.res_tag, 5'd7);
    tick();

    // NOP on lane 1
    set_lane(1, 1'b1, 4'h0, 32'd9, 32'd9, 1'b1, 5'd9);
    #1;
    chk("nop_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("nop_res_valid", bus.res_valid, 1'b1);
    chk("nop_res_data",  bus.res_data, 32'd0);
    chk("nop_res_err",   bus.res_err, 1'b0);
    chk("nop_res_lane",  bus.res_lane, 1'b1);
    tick();

    // Contention: both lanes valid for four cycles
    set_lane(0, 1'b0, 4'h0, 32'd1, 32'd1, 1'b0, 5'd1);
    set_lane(1, 1'b0, 4'h0, 32'd10, 32'd20, 1'b0, 5'd2);
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = (c < 4) ? 2'b11 : 2'b00;
      #1;
      if (c < 4) chk("cont_ready", bus.req_ready, exp_rdy[c]);
      tick();
      if (c >= 1 && c <= 4) begin
        chk("cont_res_valid", bus.res_valid, 1'b1);
        chk("cont_res_lane",  bus.res_lane, exp_lane[c-1]);
        chk("cont_res_data",  bus.res_data, exp_data[c-1]);
      end
    end

    // Backpressure: A,B,C stream with res_ready low for three cycles
    bus.req_valid = 2'b00;
    set_lane(0, 1'b1, 4'h0, 32'd100, 32'd1, 1'b0, 5'd10);
    #1;
    chk("bp_ready_a", bus.req_ready, 2'b01);
    tick();
    bus.res_ready = 1'b0;
    set_lane(0, 1'b1, 4'h0, 32'd200, 32'd2, 1'b0, 5'd11);
    #1;
    chk("bp_ready_b", bus.req_ready, 2'b01);
    tick();
    set_lane(0, 1'b1, 4'h0, 32'd300, 32'd3, 1'b0, 5'd12);
    #1;
    chk("bp_stall_ready1", bus.req_ready, 2'b00);
    tick();
    chk("bp_hold_valid", bus.res_valid, 1'b1);
    chk("bp_hold_a",     bus.res_data, 32'd101);
    chk("bp_s1_b",       bus.alu_rs1_data, 32'd200);
    #1;
    chk("bp_stall_ready2", bus.req_ready, 2'b00);
    tick();
    chk("bp_hold_a2",  bus.res_data, 32'd101);
    chk("bp_hold_tag", bus.res_tag, 5'd10);
    bus.res_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 2'b01);
    chk("bp_out_a",         bus.res_data, 32'd101);
    tick();
    bus.req_valid = 2'b00;
    chk("bp_out_b", bus.res_data, 32'd202);
    tick();
    chk("bp_out_c",   bus.res_data, 32'd303);
    chk("bp_c_valid", bus.res_valid, 1'b1);
    tick();
    chk("bp_drained", bus.res_valid, 1'b0);

    // Flush with both stages full, flush beating res_ready and a pending request
    bus.res_ready = 1'b0;
    set_lane(0, 1'b1, 4'h0, 32'd1, 32'd1, 1'b0, 5'd1);
    tick();
    set_lane(0, 1'b1, 4'h0, 32'd2, 32'd2, 1'b0, 5'd2);
    tick();
    chk("fl_full", bus.res_valid, 1'b1);
    bus.res_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_ready", bus.req_ready, 2'b00);
    tick();
    flush = 1'b0;
    bus.req_valid = 2'b00;
    chk("fl_res_valid", bus.res_valid, 1'b0);
    tick();
    chk("fl_s1_cleared", bus.res_valid, 1'b0);

    // Asynchronous reset mid-stream, then lane 0 wins after release
    set_lane(0, 1'b1, 4'h0, 32'd40, 32'd2, 1'b0, 5'd5);
    tick();
    set_lane(0, 1'b1, 4'h0, 32'd50, 32'd5, 1'b0, 5'd6);
    tick();
    chk("mr_pre_valid", bus.res_valid, 1'b1);
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("mr_res_valid", bus.res_valid, 1'b0);
    chk("mr_res_data",  bus.res_data, 32'd0);
    chk("mr_alu_rs1",   bus.alu_rs1_data, 32'd0);
    chk("mr_res_tag",   bus.res_tag, 5'd0);
    chk("mr_ready",     bus.req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_resume_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("mr_resume_valid", bus.res_valid, 1'b1);
    chk("mr_resume_lane",  bus.res_lane, 1'b0);
    chk("mr_resume_data",  bus.res_data, 32'd55);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
